// File: rtl/stream_frame_sink_if.sv
// Avalon-ST pixel stream bundle: the source drives the beat fields and the sink drives ready.
interface stream_frame_sink_if #(
    parameter int unsigned DATA_W = 8
);
    logic              sink_ready;
    logic              sink_startofpacket;
    logic              sink_endofpacket;
    logic              sink_valid;
    logic [DATA_W-1:0] sink_data;

    modport master (
        input  sink_ready,
        output sink_startofpacket,
        output sink_endofpacket,
        output sink_valid,
        output sink_data
    );

    modport slave (
        output sink_ready,
        input  sink_startofpacket,
        input  sink_endofpacket,
        input  sink_valid,
        input  sink_data
    );
endinterface

// File: rtl/stream_frame_sink.sv
// Avalon-ST video sink: buffers ready-latency beats, checks frame framing and writes each
// pixel to a linear frame-buffer port, reporting good frames and sticky protocol errors.
module stream_frame_sink #(
    parameter int unsigned WIDTH         = 640,
    parameter int unsigned HEIGHT        = 480,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned READY_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic                clock,
    input  logic                reset,
    stream_frame_sink_if.slave  st,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_en,
    input  logic                wr_wait,
    input  logic                clear_errors,
    output logic                frame_done,
    output logic [15:0]         frame_count,
    output logic                err_overflow,
    output logic                err_short,
    output logic                err_long,
    output logic                err_orphan
);

    localparam int unsigned NumPix    = WIDTH * HEIGHT;
    localparam bit          SinglePix = (NumPix == 1);
    localparam int unsigned EntW      = DATA_W + 2;
    localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ReadyThr  = FIFO_DEPTH - READY_LATENCY;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NumPix - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // ---------------- beat FIFO ----------------
    logic [EntW-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;

    logic              head_valid, head_sop, head_eop;
    logic [DATA_W-1:0] head_data;
    logic [EntW-1:0]   head;
    logic              push, pop, overflow_evt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign head_sop   = head[EntW-1];
    assign head_eop   = head[EntW-2];
    assign head_data  = head[DATA_W-1:0];

    // Capture does not re-check ready: beats arrive READY_LATENCY cycles after the grant.
    assign push         = st.sink_valid && ((count_q < CntW'(FIFO_DEPTH)) || pop);
    assign overflow_evt = st.sink_valid && !push;

    assign st.sink_ready = !reset && (count_q < CntW'(ReadyThr));

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {st.sink_startofpacket, st.sink_endofpacket, st.sink_data};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // ---------------- framing FSM and write port ----------------
    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wr_en_q;
    logic              wr_last_q;
    logic [15:0]       frame_count_q;
    logic              err_overflow_q, err_short_q, err_long_q, err_orphan_q;

    logic out_free, discard, load, accept_last;

    // The output register can take a new beat unless it holds a stalled request.
    assign out_free    = !wr_en_q || !wr_wait;
    assign discard     = head_valid && (state_q == StIdle) && !head_sop;
    assign load        = head_valid && out_free && !discard;
    assign pop         = discard || load;
    assign accept_last = wr_en_q && !wr_wait && wr_last_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            idx_q          <= '0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            wr_en_q        <= 1'b0;
            wr_last_q      <= 1'b0;
            frame_count_q  <= '0;
            err_overflow_q <= 1'b0;
            err_short_q    <= 1'b0;
            err_long_q     <= 1'b0;
            err_orphan_q   <= 1'b0;
        end else begin
            // Clear first so a coinciding error event below wins.
            if (clear_errors) begin
                err_overflow_q <= 1'b0;
                err_short_q    <= 1'b0;
                err_long_q     <= 1'b0;
                err_orphan_q   <= 1'b0;
            end
            if (overflow_evt) begin
                err_overflow_q <= 1'b1;
            end
            if (accept_last) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            if (out_free) begin
                wr_en_q   <= 1'b0;
                wr_last_q <= 1'b0;
            end
            if (discard) begin
                err_orphan_q <= 1'b1;
            end

            if (load) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= head_data;
                wr_last_q <= 1'b0;
                if (head_sop) begin
                    // A SOP always (re)starts the frame at pixel 0.
                    if (state_q == StRun) begin
                        err_short_q <= 1'b1;
                    end
                    wr_addr_q <= '0;
                    idx_q     <= ADDR_W'(1);
                    if (head_eop) begin
                        state_q <= StIdle;
                        if (SinglePix) begin
                            wr_last_q <= 1'b1;
                        end else begin
                            err_short_q <= 1'b1;
                        end
                    end else if (SinglePix) begin
                        state_q    <= StIdle;
                        err_long_q <= 1'b1;
                    end else begin
                        state_q <= StRun;
                    end
                end else if (head_eop) begin
                    wr_addr_q <= idx_q;
                    state_q   <= StIdle;
                    if (idx_q == LastIdx) begin
                        wr_last_q <= 1'b1;
                    end else begin
                        err_short_q <= 1'b1;
                    end
                end else begin
                    wr_addr_q <= idx_q;
                    if (idx_q == LastIdx) begin
                        state_q    <= StIdle;
                        err_long_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
            end
        end
    end

    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign wr_en        = wr_en_q;
    assign frame_done   = accept_last;
    assign frame_count  = frame_count_q;
    assign err_overflow = err_overflow_q;
    assign err_short    = err_short_q;
    assign err_long     = err_long_q;
    assign err_orphan   = err_orphan_q;

endmodule

// File: doc/stream_frame_sink.md
Name: stream_frame_sink

Overview:
- Avalon-ST video sink: the receiving end of the pixel stream interface (ready / startofpacket / endofpacket / valid / data) with a configurable ready latency.
- Absorbs in-flight beats in a small FIFO, checks packet framing and writes each pixel into a linear frame-buffer write port (addr = y*WIDTH + x).
- Reports completed frames and sticky protocol errors.
- Serves as the on-chip consumer for the solver/pixel-iterator stream and as the bench checker for any stream source in the design.

Parameters:
- WIDTH, 640, pixels per line.
- HEIGHT, 480, lines per frame.
- DATA_W, 8, stream data / pixel width.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- READY_LATENCY, 2, cycles from sink_ready high to the matching valid beat.
- FIFO_DEPTH, 8, beat buffer entries; must be >= READY_LATENCY+2.

Ports:
- clock  in  1  single system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- sink_ready  out  1  stream ready.
- sink_startofpacket  in  1  first pixel of frame.
- sink_endofpacket  in  1  last pixel of frame.
- sink_valid  in  1  beat valid.
- sink_data  in  DATA_W  pixel data.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  DATA_W  frame-buffer write data.
- wr_en  out  1  write request.
- wr_wait  in  1  write stall; the request is held while this is high.
- clear_errors  in  1  single-cycle pulse; clears all sticky error flags.
- frame_done  out  1  one-cycle pulse per correctly framed frame.
- frame_count  out  16  count of good frames; wraps 0xFFFF->0.
- err_overflow  out  1  sticky: a beat arrived while the FIFO was full.
- err_short  out  1  sticky: EOP or SOP seen before pixel WIDTH*HEIGHT-1.
- err_long  out  1  sticky: no EOP on pixel WIDTH*HEIGHT-1.
- err_orphan  out  1  sticky: beat received outside a packet (no SOP).

Behaviour:

Reset (asynchronous, active-high):
- While reset is high: all outputs are 0 (including sink_ready), the FIFO is empty, the FSM is in IDLE and the pixel index is 0.
- Reset mid-frame discards the frame and the buffered beats; no frame_done is produced for it.

Input side:
- A beat is captured whenever sink_valid=1. sink_ready is not re-checked at capture, per ready-latency semantics.
- sink_ready = !reset && (count < FIFO_DEPTH - READY_LATENCY), where count is the registered FIFO occupancy.
- The push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- Otherwise the beat is dropped and err_overflow is set. This only happens with a non-compliant source.
- FIFO entry = {sop, eop, data}.

Output / write side:
- The FIFO head is presented when it is non-empty.
- The head is popped when it is consumed, meaning either:
  - it is discarded by the FSM, or
  - it is written while wr_wait=0.
- wr_en, wr_addr and wr_data are registered.
- While wr_en=1 && wr_wait=1, all three hold their values and nothing is popped.
- Minimum latency from sink_valid beat to wr_en: 2 cycles (1 cycle FIFO write, 1 cycle output register).

Framing FSM at the FIFO head, with pixel index idx ranging 0..WIDTH*HEIGHT-1:
- IDLE:
  - Head with sop=1: write at addr 0, set idx=1. Go to RUN, or stay in IDLE with frame_done if eop=1 and WIDTH*HEIGHT=1.
  - Head with sop=0: discard it and set err_orphan.
- RUN, head with sop=1: set err_short, write this beat at addr 0, set idx=1 (restart the frame).
- RUN, head with eop=1:
  - If idx==WIDTH*HEIGHT-1: write it, pulse frame_done, increment frame_count, go to IDLE.
  - Otherwise: write it, set err_short, go to IDLE with no frame_done.
- RUN, head with eop=0 and idx==WIDTH*HEIGHT-1: write it, set err_long, go to IDLE. Subsequent beats are orphans until the next SOP.
- RUN, ordinary beat: write at addr idx, then increment idx.
- frame_done pulses in the cycle the final write is accepted (wr_wait=0).

Error flags:
- err_* flags are sticky until clear_errors or reset.
- If clear_errors coincides with a new error event, the flag ends set (set wins).

Test Plan:
(Bench uses WIDTH=4, HEIGHT=2, READY_LATENCY=2, FIFO_DEPTH=8; the source models valid exactly 2 cycles after ready.)
1. Clean frame of data 0x00..0x07, SOP on beat 0, EOP on beat 7, wr_wait=0 -> 8 writes to addr 0..7 with matching data; one frame_done pulse; frame_count=1; all err_*=0.
2. Same frame with wr_wait high for 20 cycles after the 2nd write -> sink_ready drops once count>=6; no err_overflow; all 8 writes complete in order.
3. EOP on beat 5 -> 6 writes; err_short=1; no frame_done. A following clean frame yields frame_done and frame_count=1.
4. Frame of 10 beats with no EOP -> 8 writes; err_long=1; beats 9-10 discarded; err_orphan=1.
5. Beats with valid=1 before any SOP, then a clean frame -> leading beats produce no writes; err_orphan=1; the frame writes addr 0..7. clear_errors -> all err_*=0.
6. Assert reset at beat 4 of a frame, then send a clean frame -> outputs are 0 during reset; afterwards exactly 8 writes, and frame_count=1 counts only the second frame.
